// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one fixed-latency memory port, one transaction at a time.
// Simultaneous requests alternate by owner; illegal data accesses are acked with d_err, no memory issue.
module mem_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_sign,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        err_q, err_d;
    logic        en_q, en_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] ird_q, ird_d;
    logic [31:0] drd_q, drd_d;

    logic gnt_data, d_bad;

    // Data wins when it is alone, or when both ask and fetch held the last grant.
    assign gnt_data = d_req & (~if_req | ~owner_q);
    assign d_bad    = (d_size == 2'b11) |
                      ((d_size == 2'b01) & d_addr[0]) |
                      ((d_size == 2'b10) & (d_addr[1:0] != 2'b00));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        err_d   = err_q;
        en_d    = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        ird_d   = ird_q;
        drd_d   = drd_q;
        case (state_q)
            IDLE: begin
                if (if_req | d_req) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_M1;
                    owner_d = gnt_data;
                    if (gnt_data) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                        size_d  = d_size;
                        sign_d  = d_sign;
                        err_d   = d_bad;
                        en_d    = ~d_bad;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = 32'h0;
                        we_d    = 1'b0;
                        size_d  = 2'b10;
                        sign_d  = 1'b0;
                        err_d   = 1'b0;
                        en_d    = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // A rejected access never touched memory, so it leaves after one cycle.
                if (err_q || cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!err_q && !we_q) begin
                        if (owner_q) drd_d = mem_rdata;
                        else         ird_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            ird_q   <= 32'h0;
            drd_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            ird_q   <= ird_d;
            drd_q   <= drd_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign if_ack    = (state_q == DONE) & ~owner_q;
    assign d_ack     = (state_q == DONE) & owner_q;
    assign d_err     = d_ack & err_q;
    assign if_rdata  = ird_q;
    assign d_rdata   = drd_q;
    assign mem_en    = en_q;
    assign mem_we    = en_q & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;
    assign mem_sign  = sign_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline model checked every cycle, plus directed literal checks.
module tb_mem_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0, reset = 1'b0, rst_x = 1'b0;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_sign = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [1:0]  d_size = '0;
    logic        if_ack, d_ack, d_err, mem_en, mem_we, mem_sign, busy, owner;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;

    // Memory contents as a pure function of the address; the DUT holds mem_addr so any latency works.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    assign mem_rdata = memf(mem_addr);

    mem_arbiter #(.MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_sign(d_sign), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_sign(mem_sign), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // Latency-extreme instances: fetch requested continuously from their own reset release.
    logic        xreq = 1'b1, xzero = 1'b0;
    logic [31:0] xaddr = 32'h100, xz32 = '0;
    logic [1:0]  xz2 = '0;
    logic        a1_if_ack, a1_d_ack, a1_d_err, a1_en, a1_we, a1_sign, a1_busy, a1_owner;
    logic [31:0] a1_ird, a1_drd, a1_addr, a1_wd, a1_mrd;
    logic [1:0]  a1_size;
    logic        b_if_ack, b_d_ack, b_d_err, b_en, b_we, b_sign, b_busy, b_owner;
    logic [31:0] b_ird, b_drd, b_addr, b_wd, b_mrd;
    logic [1:0]  b_size;
    assign a1_mrd = memf(a1_addr);
    assign b_mrd  = memf(b_addr);

    mem_arbiter #(.MEM_LATENCY(1)) u_l1 (
        .clk(clk), .reset(rst_x), .if_req(xreq), .if_addr(xaddr), .if_ack(a1_if_ack),
        .if_rdata(a1_ird), .d_req(xzero), .d_we(xzero), .d_addr(xz32), .d_wdata(xz32),
        .d_size(xz2), .d_sign(xzero), .d_ack(a1_d_ack), .d_err(a1_d_err), .d_rdata(a1_drd),
        .mem_en(a1_en), .mem_we(a1_we), .mem_addr(a1_addr), .mem_wdata(a1_wd),
        .mem_size(a1_size), .mem_sign(a1_sign), .mem_rdata(a1_mrd), .busy(a1_busy), .owner(a1_owner)
    );
    mem_arbiter #(.MEM_LATENCY(15)) u_l15 (
        .clk(clk), .reset(rst_x), .if_req(xreq), .if_addr(xaddr), .if_ack(b_if_ack),
        .if_rdata(b_ird), .d_req(xzero), .d_we(xzero), .d_addr(xz32), .d_wdata(xz32),
        .d_size(xz2), .d_sign(xzero), .d_ack(b_d_ack), .d_err(b_d_err), .d_rdata(b_drd),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd),
        .mem_size(b_size), .mem_sign(b_sign), .mem_rdata(b_mrd), .busy(b_busy), .owner(b_owner)
    );

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Instance with continuous fetch: grants every L+2 edges counted from its first live edge rx=0.
    task automatic chkx(input string nm, input int L, input int rx, input logic ack,
                        input logic bsy, input logic en, input logic [31:0] rd);
        int ph;
        ph = (rx >= 0) ? rx % (L + 2) : -1;
        chk({nm, "_ack"},  32'(ack), 32'(ph == L));
        chk({nm, "_busy"}, 32'(bsy), 32'(ph >= 0 && ph <= L));
        chk({nm, "_en"},   32'(en),  32'(ph == 0));
        chk({nm, "_rd"},   rd, (rx >= L) ? 32'hDEADBEEF : 32'h0);
    endtask

    // Timeline model: a grant at edge g finishes (ack cycle) after edge g+LAT, or g+1 if rejected;
    // the arbiter can sample again two edges after the ack edge.
    int k = 0, rx = -1, m_gnt = 0, m_ack = 0, m_free = 0;
    bit m_act, m_who, m_err, m_we, m_owner, m_sign, m_en;
    logic [31:0] m_addr, m_wd, m_ird, m_drd;
    logic [1:0]  m_size;

    initial forever begin
        @(posedge clk);
        k++;
        if (!reset) begin
            m_act = 0; m_free = 0; m_owner = 0; m_who = 0; m_err = 0; m_we = 0;
            m_addr = '0; m_wd = '0; m_ird = '0; m_drd = '0; m_size = '0; m_sign = 0;
        end else begin
            if (m_act && k == m_ack && !m_err && !m_we) begin
                if (m_who) m_drd = memf(m_addr);
                else       m_ird = memf(m_addr);
            end
            if (m_act && k > m_ack) begin
                m_act  = 0;
                m_free = m_ack + 2;
            end
            if (!m_act && k >= m_free && (if_req || d_req)) begin
                m_who   = (if_req && d_req) ? !m_owner : d_req;
                m_owner = m_who;
                m_act   = 1;
                m_gnt   = k;
                if (m_who) begin
                    m_addr = d_addr; m_wd = d_wdata; m_we = d_we; m_size = d_size; m_sign = d_sign;
                    m_err  = (d_size == 2'd3) || (d_size == 2'd1 && d_addr[0]) ||
                             (d_size == 2'd2 && d_addr[1:0] != 2'd0);
                end else begin
                    m_addr = if_addr; m_we = 0; m_size = 2'd2; m_sign = 0; m_err = 0;
                end
                m_ack = m_err ? k + 1 : k + LAT;
            end
        end
        if (rst_x) rx++;
        else       rx = -1;
        #2;
        m_en = m_act && k == m_gnt && !m_err;
        chk("busy",     32'(busy),     32'(m_act));
        chk("mem_en",   32'(mem_en),   32'(m_en));
        chk("mem_we",   32'(mem_we),   32'(m_en && m_we));
        chk("if_ack",   32'(if_ack),   32'(m_act && k == m_ack && !m_who));
        chk("d_ack",    32'(d_ack),    32'(m_act && k == m_ack && m_who));
        chk("d_err",    32'(d_err),    32'(m_act && k == m_ack && m_who && m_err));
        chk("owner",    32'(owner),    32'(m_owner));
        chk("mem_addr", mem_addr,      m_addr);
        chk("mem_size", 32'(mem_size), 32'(m_size));
        chk("mem_sign", 32'(mem_sign), 32'(m_sign));
        chk("if_rdata", if_rdata,      m_ird);
        chk("d_rdata",  d_rdata,       m_drd);
        if (m_en && m_we) chk("mem_wdata", mem_wdata, m_wd);
        chkx("l1",  1,  rx, a1_if_ack, a1_busy, a1_en, a1_ird);
        chkx("l15", 15, rx, b_if_ack,  b_busy,  b_en,  b_ird);
    end

    // One request held until its ack; lat counts negedges from the drive point to the ack cycle.
    task automatic xact(input bit isd, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input bit sg,
                        output int lat, output int en_n, output int we_n, output bit ev);
        @(negedge clk);
        if (isd) begin
            d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_size = sz; d_sign = sg;
        end else begin
            if_req = 1; if_addr = a;
        end
        lat = 0; en_n = 0; we_n = 0; ev = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mem_en) en_n++;
            if (mem_we) we_n++;
            if ((isd && d_ack) || (!isd && if_ack)) begin
                lat = i;
                ev  = d_err;
                break;
            end
        end
        if_req = 0; d_req = 0;
        chk("ack_seen", 32'(lat != 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, en_n, we_n, na, na2, n1a, n1b, n15a, n15b;
        int ai[4];
        bit aw[4];
        bit ev;

        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        chk("rst_mem",  {30'd0, mem_en, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);

        // Latency extremes: first ack and ack-to-ack spacing in negedges after release.
        @(negedge clk);
        rst_x = 1;
        n1a = 0; n1b = 0; n15a = 0; n15b = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (a1_if_ack) begin
                if (n1a == 0) n1a = i;
                else if (n1b == 0) n1b = i;
            end
            if (b_if_ack) begin
                if (n15a == 0) n15a = i;
                else if (n15b == 0) n15b = i;
            end
        end
        chk("l1_first",   32'(n1a),        32'd2);
        chk("l1_period",  32'(n1b - n1a),  32'd3);
        chk("l15_first",  32'(n15a),       32'd16);
        chk("l15_period", 32'(n15b - n15a), 32'd17);

        // Both requesting straight out of reset: data, fetch, data, fetch, four cycles apart.
        if_req = 1; d_req = 1; if_addr = 32'h100; d_addr = 32'h40; d_size = 2'd2; d_we = 0;
        reset = 1;
        na = 0;
        for (int i = 1; i <= 40 && na < 4; i++) begin
            @(negedge clk);
            if (d_ack || if_ack) begin
                ai[na] = i;
                aw[na] = d_ack;
                na++;
            end
        end
        if_req = 0; d_req = 0;
        chk("rr_count", 32'(na), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk("rr_who", 32'(aw[j]), 32'(j % 2 == 0));
            chk("rr_at",  32'(ai[j]), 32'(3 + 4 * j));
        end
        chk("rr_drd", d_rdata,  32'hBEAF0040);
        chk("rr_ird", if_rdata, 32'hDEADBEEF);

        xact(0, 0, 32'h100, 32'h0, 2'd2, 0, lat, en_n, we_n, ev);
        chk("f_lat", 32'(lat), 32'd3);
        chk("f_en",  32'(en_n), 32'd1);
        chk("f_rd",  if_rdata, 32'hDEADBEEF);

        xact(1, 1, 32'h20, 32'h12345678, 2'd2, 0, lat, en_n, we_n, ev);
        chk("st_lat",   32'(lat),  32'd3);
        chk("st_we",    32'(we_n), 32'd1);
        chk("st_err",   32'(ev),   32'd0);
        chk("st_drd",   d_rdata,   32'hBEAF0040);
        chk("st_addr",  mem_addr,  32'h20);
        chk("st_wdata", mem_wdata, 32'h12345678);

        xact(1, 0, 32'h22, 32'h0, 2'd2, 0, lat, en_n, we_n, ev);
        chk("ew_lat", 32'(lat),  32'd2);
        chk("ew_en",  32'(en_n), 32'd0);
        chk("ew_err", 32'(ev),   32'd1);
        chk("ew_drd", d_rdata,   32'hBEAF0040);

        xact(1, 0, 32'h40, 32'h0, 2'd3, 0, lat, en_n, we_n, ev);
        chk("er_lat", 32'(lat),  32'd2);
        chk("er_en",  32'(en_n), 32'd0);
        chk("er_err", 32'(ev),   32'd1);

        xact(1, 0, 32'h21, 32'h0, 2'd1, 0, lat, en_n, we_n, ev);
        chk("eh_lat", 32'(lat), 32'd2);
        chk("eh_err", 32'(ev),  32'd1);

        xact(1, 0, 32'h22, 32'h0, 2'd1, 1, lat, en_n, we_n, ev);
        chk("h_lat",  32'(lat), 32'd3);
        chk("h_err",  32'(ev),  32'd0);
        chk("h_drd",  d_rdata,  32'hBECD0022);
        chk("h_size", 32'(mem_size), 32'd1);
        chk("h_sign", 32'(mem_sign), 32'd1);

        // Reset in the middle of a fetch: everything clears at once and the fetch is dropped.
        @(negedge clk);
        if_req = 1; if_addr = 32'h200;
        @(negedge clk);
        chk("rm_busy_pre", 32'(busy), 32'd1);
        #1 reset = 0;
        #1;
        chk("rm_busy",  32'(busy),   32'd0);
        chk("rm_en",    32'(mem_en), 32'd0);
        chk("rm_ird",   if_rdata,    32'h0);
        chk("rm_drd",   d_rdata,     32'h0);
        chk("rm_addr",  mem_addr,    32'h0);
        if_req = 0;
        na2 = 0;
        repeat (5) begin
            @(negedge clk);
            if (if_ack) na2++;
        end
        chk("rm_no_ack", 32'(na2), 32'd0);
        reset = 1;
        xact(0, 0, 32'h300, 32'h0, 2'd2, 0, lat, en_n, we_n, ev);
        chk("rm_lat", 32'(lat), 32'd3);
        chk("rm_rd",  if_rdata, 32'hBDEF0300);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
